perc_train: RTL and testbench

PERC_TRAIN -- requirements
Module: perc_train

---
 rtl/perc_pkg.sv | 32 +++
 rtl/perc_train_if.sv | 34 +++
 rtl/perc_sat_step.sv | 29 ++
 rtl/perc_train.sv | 138 +++++++++++++
 tb/tb_perc_train.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/perc_pkg.sv
// -----------------------------------------------------------------------------
// perc_pkg -- shared definitions for the perc_train perceptron trainer.
//   DEF_WIDTH / DEF_WEIGHT_W / DEF_THRESH : default parameter values
//   state_t        : FSM state encoding (IDLE, ACCUM, DECIDE, UPDATE, DONE)
//   sum_w()        : accumulator width that can never overflow
//   reset_weight() : initial value of weight i, 2^(i mod weight_w)
// -----------------------------------------------------------------------------
package perc_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_WEIGHT_W = 4;
   localparam int DEF_THRESH   = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_DECIDE = 3'd2,
      ST_UPDATE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // WIDTH terms of at most 2^WEIGHT_W-1 each fit in WEIGHT_W+clog2(WIDTH)
   // bits; the extra bit leaves headroom.
   function automatic int sum_w(input int width, input int weight_w);
      return weight_w + $clog2(width) + 1;
   endfunction

   function automatic int reset_weight(input int idx, input int weight_w);
      return 1 << (idx % weight_w);
   endfunction

endpackage

// File: rtl/perc_train_if.sv
// -----------------------------------------------------------------------------
// perc_train_if -- sample/result bus of perc_train.
//   in_valid/in_ready/data_in/target : sample handshake (master -> slave)
//   out_valid/data_out/err           : result of the last sample
//   weights                          : current weights, weight i at [i*WEIGHT_W +: WEIGHT_W]
//   dbg_state                        : FSM state, for observation only
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_valid may be raised at any time; it is ignored while
// in_ready is 0. out_valid is a one-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
interface perc_train_if #(
   parameter int WIDTH    = perc_pkg::DEF_WIDTH,
   parameter int WEIGHT_W = perc_pkg::DEF_WEIGHT_W
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          data_in;
   logic                      target;
   logic                      out_valid;
   logic                      data_out;
   logic                      err;
   logic [WIDTH*WEIGHT_W-1:0] weights;
   perc_pkg::state_t          dbg_state;

   modport master (
      output in_valid, data_in, target,
      input  in_ready, out_valid, data_out, err, weights, dbg_state
   );

   modport slave (
      input  in_valid, data_in, target,
      output in_ready, out_valid, data_out, err, weights, dbg_state
   );
endinterface

// File: rtl/perc_sat_step.sv
// -----------------------------------------------------------------------------
// perc_sat_step -- saturating +/-1 step of one unsigned weight.
//   i_w  : current weight
//   i_en : 1 = apply a step, 0 = pass i_w through
//   i_up : 1 = increment (clamps at all-ones), 0 = decrement (clamps at 0)
//   o_w  : stepped weight
// -----------------------------------------------------------------------------
module perc_sat_step #(
   parameter int WEIGHT_W = 4
) (
   input  logic [WEIGHT_W-1:0] i_w,
   input  logic                i_en,
   input  logic                i_up,
   output logic [WEIGHT_W-1:0] o_w
);
   localparam logic [WEIGHT_W-1:0] W_MAX = '1;
   localparam logic [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);

   always_comb begin
      o_w = i_w;
      if (i_en) begin
         if (i_up) begin
            if (i_w != W_MAX) o_w = i_w + W_ONE;
         end else begin
            if (i_w != '0) o_w = i_w - W_ONE;
         end
      end
   end
endmodule

// File: rtl/perc_train.sv
// -----------------------------------------------------------------------------
// perc_train -- serial perceptron with online weight training.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : perc_train_if slave (sample handshake, result, weights, dbg_state)
// Parameters: WIDTH (inputs), WEIGHT_W (bits per weight), THRESH (fire level).
// A sample is accumulated one input per cycle (ACCUM, WIDTH cycles), compared
// against THRESH (DECIDE), then the weights are trained (UPDATE) and the result
// is flagged for one cycle (DONE).
// Macro PERC_TRAIN_UPDATE_EN: defined = UPDATE applies the perceptron rule;
// undefined = inference only, weights keep their reset values. Timing and
// err reporting are identical in both builds.
// -----------------------------------------------------------------------------
module perc_train
   import perc_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int WEIGHT_W = DEF_WEIGHT_W,
   parameter int THRESH   = DEF_THRESH
) (
   input  logic         clk,
   input  logic         rst_n,
   perc_train_if.slave  bus
);
   localparam int SUM_W = sum_w(WIDTH, WEIGHT_W);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [31:0]      THRESH_U = 32'(THRESH);

`ifdef PERC_TRAIN_UPDATE_EN
   localparam bit UPD_EN = 1'b1;
`else
   localparam bit UPD_EN = 1'b0;
`endif

   function automatic logic [WIDTH*WEIGHT_W-1:0] init_weights();
      logic [WIDTH*WEIGHT_W-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++)
         v[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(reset_weight(i, WEIGHT_W));
      return v;
   endfunction

   localparam logic [WIDTH*WEIGHT_W-1:0] RST_WEIGHTS = init_weights();

   state_t                    r_state;
   logic [IDX_W-1:0]          r_idx;
   logic [WIDTH-1:0]          r_data;
   logic                      r_target;
   logic [SUM_W-1:0]          r_sum;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic                      r_data_out;
   logic                      r_err;
   logic [WIDTH*WEIGHT_W-1:0] r_weights;

   logic [WEIGHT_W-1:0]       w_weight [WIDTH];
   logic [WIDTH*WEIGHT_W-1:0] w_weights_next;
   logic [WEIGHT_W-1:0]       w_term;
   logic                      w_fire;

   // One saturating stepper per weight. The step is enabled only for
   // misclassified samples and only on the inputs that were 1.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_w
      assign w_weight[gi] = r_weights[gi*WEIGHT_W +: WEIGHT_W];

      perc_sat_step #(.WEIGHT_W(WEIGHT_W)) u_step (
         .i_w  (w_weight[gi]),
         .i_en (UPD_EN && r_err && r_data[gi]),
         .i_up (r_target),
         .o_w  (w_weights_next[gi*WEIGHT_W +: WEIGHT_W])
      );
   end

   assign w_term = r_data[r_idx] ? w_weight[r_idx] : '0;
   assign w_fire = (32'(r_sum) >= THRESH_U);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_data      <= '0;
         r_target    <= 1'b0;
         r_sum       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_data_out  <= 1'b0;
         r_err       <= 1'b0;
         r_weights   <= RST_WEIGHTS;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_data     <= bus.data_in;
                  r_target   <= bus.target;
                  r_sum      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               r_sum <= r_sum + SUM_W'(w_term);
               if (r_idx == LAST_IDX) r_state <= ST_DECIDE;
               else                   r_idx   <= r_idx + IDX_W'(1);
            end
            ST_DECIDE: begin
               r_data_out <= w_fire;
               r_err      <= (w_fire != r_target);
               r_state    <= ST_UPDATE;
            end
            ST_UPDATE: begin
               // w_weights_next equals r_weights when no step is enabled.
               r_weights   <= w_weights_next;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               r_in_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_in_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data_out;
   assign bus.err       = r_err;
   assign bus.weights   = r_weights;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_perc_train.sv
// -----------------------------------------------------------------------------
// tb_perc_train -- bench for perc_train. A behavioural model tracks each
// sample as a countdown of remaining busy cycles and computes the decision
// and the trained weights with plain integer arithmetic; a compare process
// checks every DUT output against it on each falling edge. A second DUT
// with THRESH=20 exercises weight saturation.
// -----------------------------------------------------------------------------
module tb_perc_train;
   import perc_pkg::*;

   localparam int W  = 4;
   localparam int WW = 4;
   localparam int TH = 10;
   localparam int WMAX = (1 << WW) - 1;

`ifdef PERC_TRAIN_UPDATE_EN
   localparam bit UPD = 1'b1;
`else
   localparam bit UPD = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   perc_train_if #(.WIDTH(W), .WEIGHT_W(WW)) bus   ();
   perc_train_if #(.WIDTH(W), .WEIGHT_W(WW)) bus_b ();

   perc_train #(.WIDTH(W), .WEIGHT_W(WW), .THRESH(TH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   perc_train #(.WIDTH(W), .WEIGHT_W(WW), .THRESH(20)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_cnt = busy cycles left after acceptance: WIDTH accumulate cycles plus
   // decide, update and done. Decision lands when 2 remain, weights and the
   // out_valid pulse when 1 remains, ready again at 0.
   int         m_cnt = 0;
   int         m_w [W];
   logic [W-1:0] m_data;
   logic       m_tgt;
   logic       exp_dout;
   logic       exp_err;

   function automatic logic [W*WW-1:0] pack_w();
      logic [W*WW-1:0] v;
      for (int i = 0; i < W; i++) v[i*WW +: WW] = WW'(m_w[i]);
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt    <= 0;
         exp_dout <= 1'b0;
         exp_err  <= 1'b0;
         for (int i = 0; i < W; i++) m_w[i] <= 1 << (i % WW);
      end else if (m_cnt == 0) begin
         if (bus.in_valid) begin
            m_data <= bus.data_in;
            m_tgt  <= bus.target;
            m_cnt  <= W + 3;
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 3) begin
            int   s;
            logic d;
            s = 0;
            for (int i = 0; i < W; i++) if (m_data[i]) s = s + m_w[i];
            d = (s >= TH);
            exp_dout <= d;
            exp_err  <= (d != m_tgt);
         end
         if (m_cnt == 2 && UPD && exp_err) begin
            for (int i = 0; i < W; i++)
               if (m_data[i])
                  m_w[i] <= m_tgt ? ((m_w[i] < WMAX) ? m_w[i] + 1 : WMAX)
                                  : ((m_w[i] > 0) ? m_w[i] - 1 : 0);
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  32'(bus.in_ready),  32'(m_cnt == 0));
         check("out_valid", 32'(bus.out_valid), 32'(m_cnt == 1));
         check("data_out",  32'(bus.data_out),  32'(exp_dout));
         check("err",       32'(bus.err),       32'(exp_err));
         check("weights",   32'(bus.weights),   32'(pack_w()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] d, input logic t, input bit noise);
      int k;
      k = 0;
      @(posedge clk); #1;
      while (m_cnt != 0 && k < 200) begin
         // Busy: optionally wiggle in_valid, but never at the edge that frees the block.
         if (noise && m_cnt > 1) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.data_in  = W'($urandom);
            bus.target   = 1'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      if (k >= 200) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: actual=busy required=idle at %0t", $time);
      end
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      bus.target   = t;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Called right after send(): counts falling edges until out_valid.
   task automatic wait_result(output int lat);
      lat = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid || lat >= 30) break;
         lat++;
      end
   endtask

   task automatic send_b(input int n);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      bus_b.in_valid = 1'b1;
      bus_b.data_in  = 4'b0001;
      bus_b.target   = 1'b1;
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_b.out_valid || lat >= 30) break;
         lat++;
      end
      check("b_latency",  32'(lat), 32'(W + 2));
      check("b_data_out", 32'(bus_b.data_out), 32'd0);
      check("b_err",      32'(bus_b.err), 32'd1);
      check("b_weight0",  32'(bus_b.weights[3:0]),
            UPD ? ((n + 1 > WMAX) ? 32'(WMAX) : 32'(n + 1)) : 32'd1);
      check("b_weights_hi", 32'(bus_b.weights[15:4]), 32'h842);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int pulses;
      bus.in_valid   = 1'b0; bus.data_in   = '0; bus.target   = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.data_in = '0; bus_b.target = 1'b0;

      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_weights",   32'(bus.weights),   32'h8421);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data_out",  32'(bus.data_out),  32'd0);

      // THRESH=20 unit: weight0 climbs by one per sample and saturates at 15.
      for (int n = 1; n <= 20; n++) send_b(n);

      // 1011, target 1: sum 11 fires, no error.
      send(4'b1011, 1'b1, 1'b0);
      wait_result(lat);
      check("lat_1011_t1",  32'(lat), 32'(W + 2));
      check("dout_1011_t1", 32'(bus.data_out), 32'd1);
      check("err_1011_t1",  32'(bus.err), 32'd0);
      check("w_1011_t1",    32'(bus.weights), 32'h8421);

      // 1011, target 0: misclassified, trained weights drop on inputs 0,1,3.
      send(4'b1011, 1'b0, 1'b0);
      wait_result(lat);
      check("lat_1011_t0",  32'(lat), 32'(W + 2));
      check("dout_1011_t0", 32'(bus.data_out), 32'd1);
      check("err_1011_t0",  32'(bus.err), 32'd1);
      check("w_1011_t0",    32'(bus.weights), UPD ? 32'h7410 : 32'h8421);

      // Repeat: trained sum 7+1+0 = 8 no longer fires.
      send(4'b1011, 1'b0, 1'b0);
      wait_result(lat);
      check("dout_repeat", 32'(bus.data_out), UPD ? 32'd0 : 32'd1);
      check("err_repeat",  32'(bus.err),      UPD ? 32'd0 : 32'd1);

      // Reset in the middle of accumulation: sample dropped, weights restored.
      send(4'b0110, 1'b1, 1'b0);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_weights",   32'(bus.weights),   32'h8421);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      pulses = 0;
      repeat (W + 6) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);

      // in_valid held high: one sample per WIDTH+4 edges (accumulate, decide,
      // update, done, idle), so 42 cycles hold 5 result pulses.
      bus.in_valid = 1'b1;
      pulses = 0;
      repeat (42) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
         bus.data_in = W'($urandom);
         bus.target  = 1'($urandom);
      end
      check("stream_pulses", 32'(pulses), 32'd5);
      bus.in_valid = 1'b0;

      // Randomised samples with random gaps and in_valid noise while busy.
      repeat (25) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(W'($urandom), 1'($urandom), 1'b1);
      end
      send(4'b0000, 1'b0, 1'b0);
      repeat (W + 5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
